// File: rtl/quiz_pkg.sv
// Shared constants and types for the quiz round controller: phase encoding,
// player/score limits and the player-count request mask.
package quiz_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int SCORE_W     = 7;

  typedef logic [SCORE_W-1:0] score_t;

  localparam score_t SCORE_MAX = 7'd99;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_OPEN   = 3'd1,
    PH_ANSWER = 3'd2,
    PH_SHOW   = 3'd3,
    PH_OVER   = 3'd4
  } phase_t;

  function automatic logic [MAX_PLAYERS-1:0] player_mask(input logic [2:0] count);
    case (count)
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/quiz_round_control_if.sv
// Host/player event inputs, game settings and game-state outputs of the
// quiz round controller; master drives events/settings, slave is the controller.
interface quiz_round_control_if;
  import quiz_pkg::*;

  logic                   tick_1hz;
  logic                   start;
  logic                   judge_ok;
  logic                   judge_fail;
  logic [MAX_PLAYERS-1:0] buzz;
  logic [2:0]             player_count;
  logic [3:0]             question_count;
  logic [6:0]             answer_time;
  logic [6:0]             win_score;
  logic [3:0]             success_score;
  logic [3:0]             fail_score;

  logic [2:0]             phase;
  logic [3:0]             question_no;
  logic [6:0]             countdown;
  logic [1:0]             responder;
  logic                   responder_valid;
  logic [27:0]            scores;
  logic [1:0]             winner;
  logic                   winner_valid;

  modport master (
    output tick_1hz, start, judge_ok, judge_fail, buzz,
    output player_count, question_count, answer_time, win_score,
    output success_score, fail_score,
    input  phase, question_no, countdown, responder, responder_valid,
    input  scores, winner, winner_valid
  );

  modport slave (
    input  tick_1hz, start, judge_ok, judge_fail, buzz,
    input  player_count, question_count, answer_time, win_score,
    input  success_score, fail_score,
    output phase, question_no, countdown, responder, responder_valid,
    output scores, winner, winner_valid
  );

endinterface

// File: rtl/buzz_arbiter.sv
// Picks one responder from the buzz requests of active players.
// ROTATING_PRIORITY_EN selects round-robin; otherwise lowest index wins.
module buzz_arbiter
  import quiz_pkg::*;
(
`ifdef ROTATING_PRIORITY_EN
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   update,
`endif
  input  logic [MAX_PLAYERS-1:0] req,
  input  logic [2:0]             player_count,
  output logic [1:0]             grant,
  output logic                   grant_valid
);

  logic [MAX_PLAYERS-1:0] req_m;

  assign req_m = req & player_mask(player_count);

`ifdef ROTATING_PRIORITY_EN
  // ptr_q is where the next search starts, not the last winner
  logic [1:0] ptr_q;
  logic [2:0] idx;
  logic [2:0] nxt;

  always_comb begin
    grant       = 2'd0;
    grant_valid = 1'b0;
    idx         = 3'd0;
    for (int k = 0; k < MAX_PLAYERS; k++) begin
      if (!grant_valid && (3'(k) < player_count)) begin
        idx = {1'b0, ptr_q} + 3'(k);
        if (idx >= player_count) idx = idx - player_count;
        if (req_m[idx[1:0]]) begin
          grant       = idx[1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt = {1'b0, grant} + 3'd1;
    if (nxt >= player_count) nxt = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) ptr_q <= 2'd0;
    else if (update && grant_valid) ptr_q <= nxt[1:0];
  end
`else
  always_comb begin
    grant       = 2'd0;
    grant_valid = 1'b0;
    for (int i = MAX_PLAYERS-1; i >= 0; i--) begin
      if (req_m[i]) begin
        grant       = 2'(i);
        grant_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/quiz_round_control.sv
// Quiz game sequencer: buzzer window, answer countdown, scoring and winner.
// Define ROTATING_PRIORITY_EN for round-robin buzz tie-break.
module quiz_round_control
  import quiz_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  quiz_round_control_if.slave  bus
);

  phase_t     phase_q;
  logic [3:0] qno_q;
  logic [6:0] cd_q;
  logic [1:0] resp_q;
  logic       resp_vld_q;
  score_t     score_q [MAX_PLAYERS];
  logic [1:0] win_q;
  logic       win_vld_q;

  logic [2:0] pc_l;
  logic [3:0] qc_l;
  logic [6:0] at_l;
  logic [6:0] ws_l;
  logic [3:0] ss_l;
  logic [3:0] fs_l;

  logic [1:0] grant;
  logic       grant_valid;
  logic       game_start;

  logic [MAX_PLAYERS-1:0] act;
  logic       any_win;
  logic [1:0] win_idx;
  score_t     max_val;
  logic [1:0] max_idx;
  logic       max_tie;

  function automatic score_t sat_add(input score_t s, input logic [3:0] d);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {4'b0, d};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

  function automatic score_t sat_sub(input score_t s, input logic [3:0] d);
    return (s > {3'b0, d}) ? s - {3'b0, d} : '0;
  endfunction

  assign game_start = (phase_q == PH_IDLE) && bus.start;

  buzz_arbiter u_arb (
`ifdef ROTATING_PRIORITY_EN
    .clk          (clk),
    .rst          (rst),
    .clear        (game_start),
    .update       (phase_q == PH_OPEN),
`endif
    .req          (bus.buzz),
    .player_count (pc_l),
    .grant        (grant),
    .grant_valid  (grant_valid)
  );

  // End-of-question evaluation over the active players only
  always_comb begin
    act     = player_mask(pc_l);
    any_win = 1'b0;
    win_idx = 2'd0;
    max_val = '0;
    max_idx = 2'd0;
    max_tie = 1'b0;
    for (int i = MAX_PLAYERS-1; i >= 0; i--) begin
      if (act[i] && score_q[i] >= ws_l) begin
        any_win = 1'b1;
        win_idx = 2'(i);
      end
    end
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (act[i]) begin
        if (i == 0 || score_q[i] > max_val) begin
          max_val = score_q[i];
          max_idx = 2'(i);
          max_tie = 1'b0;
        end else if (score_q[i] == max_val) begin
          max_tie = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_IDLE;
      qno_q      <= 4'd0;
      cd_q       <= 7'd0;
      resp_q     <= 2'd0;
      resp_vld_q <= 1'b0;
      win_q      <= 2'd0;
      win_vld_q  <= 1'b0;
      for (int i = 0; i < MAX_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      case (phase_q)
        PH_IDLE: if (bus.start) begin
          pc_l       <= bus.player_count;
          qc_l       <= bus.question_count;
          at_l       <= bus.answer_time;
          ws_l       <= bus.win_score;
          ss_l       <= bus.success_score;
          fs_l       <= bus.fail_score;
          for (int i = 0; i < MAX_PLAYERS; i++) score_q[i] <= '0;
          qno_q      <= 4'd1;
          cd_q       <= bus.answer_time;
          resp_q     <= 2'd0;
          resp_vld_q <= 1'b0;
          win_q      <= 2'd0;
          win_vld_q  <= 1'b0;
          phase_q    <= PH_OPEN;
        end
        PH_OPEN: begin
          if (grant_valid) begin
            resp_q     <= grant;
            resp_vld_q <= 1'b1;
            cd_q       <= at_l;
            phase_q    <= PH_ANSWER;
          end else if (bus.tick_1hz) begin
            if (cd_q == 7'd1) begin
              cd_q       <= 7'd0;
              resp_vld_q <= 1'b0;
              phase_q    <= PH_SHOW;
            end else if (cd_q != 7'd0) begin
              cd_q <= cd_q - 7'd1;
            end
          end
        end
        PH_ANSWER: begin
          // Judge beats a same-cycle timeout; countdown keeps its value then
          if (bus.judge_ok) begin
            score_q[resp_q] <= sat_add(score_q[resp_q], ss_l);
            phase_q         <= PH_SHOW;
          end else if (bus.judge_fail || (bus.tick_1hz && cd_q == 7'd1)) begin
            score_q[resp_q] <= sat_sub(score_q[resp_q], fs_l);
            if (!bus.judge_fail) cd_q <= 7'd0;
            phase_q         <= PH_SHOW;
          end else if (bus.tick_1hz && cd_q != 7'd0) begin
            cd_q <= cd_q - 7'd1;
          end
        end
        PH_SHOW: begin
          if (any_win) begin
            win_q     <= win_idx;
            win_vld_q <= 1'b1;
            phase_q   <= PH_OVER;
          end else if (qno_q == qc_l) begin
            win_q     <= max_tie ? 2'd0 : max_idx;
            win_vld_q <= !max_tie;
            phase_q   <= PH_OVER;
          end else if (bus.start) begin
            qno_q      <= qno_q + 4'd1;
            resp_vld_q <= 1'b0;
            cd_q       <= at_l;
            phase_q    <= PH_OPEN;
          end
        end
        PH_OVER: if (bus.start) phase_q <= PH_IDLE;
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.phase           = phase_q;
    bus.question_no     = qno_q;
    bus.countdown       = cd_q;
    bus.responder       = resp_q;
    bus.responder_valid = resp_vld_q;
    bus.winner          = win_q;
    bus.winner_valid    = win_vld_q;
    for (int i = 0; i < MAX_PLAYERS; i++) bus.scores[7*i +: 7] = score_q[i];
  end

endmodule

// File: tb/tb_quiz_round_control.sv
// Bench for quiz_round_control: directed game scenarios, then random play,
// all cycles compared against a rule-level reference model.
module tb_quiz_round_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quiz_round_control_if bus ();

  quiz_round_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       t_tick, t_start, t_ok, t_fail;
  logic [3:0] t_buzz;
  int         s_pc, s_qc, s_at, s_ws, s_ss, s_fs;

  assign bus.tick_1hz       = t_tick;
  assign bus.start          = t_start;
  assign bus.judge_ok       = t_ok;
  assign bus.judge_fail     = t_fail;
  assign bus.buzz           = t_buzz;
  assign bus.player_count   = 3'(s_pc);
  assign bus.question_count = 4'(s_qc);
  assign bus.answer_time    = 7'(s_at);
  assign bus.win_score      = 7'(s_ws);
  assign bus.success_score  = 4'(s_ss);
  assign bus.fail_score     = 4'(s_fs);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: game rules with plain integers
  int m_phase, m_q, m_cd, m_resp, m_rv, m_win, m_wv, m_ptr;
  int m_sc[4];
  int l_pc, l_qc, l_at, l_ws, l_ss, l_fs;

  task automatic model_edge();
    int pick, lead, best, nbest, bidx;
    if (rst) begin
      m_phase = 0; m_q = 0; m_cd = 0; m_resp = 0; m_rv = 0;
      m_win = 0; m_wv = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
      return;
    end
    case (m_phase)
      0: if (t_start) begin
        l_pc = s_pc; l_qc = s_qc; l_at = s_at; l_ws = s_ws; l_ss = s_ss; l_fs = s_fs;
        for (int i = 0; i < 4; i++) m_sc[i] = 0;
        m_q = 1; m_cd = s_at; m_resp = 0; m_rv = 0; m_win = 0; m_wv = 0;
        m_ptr = 0; m_phase = 1;
      end
      1: begin
        pick = -1;
`ifdef ROTATING_PRIORITY_EN
        for (int k = 0; k < l_pc; k++)
          if (pick < 0 && t_buzz[(m_ptr + k) % l_pc]) pick = (m_ptr + k) % l_pc;
`else
        for (int i = 0; i < l_pc; i++)
          if (pick < 0 && t_buzz[i]) pick = i;
`endif
        if (pick >= 0) begin
          m_resp = pick; m_rv = 1; m_cd = l_at; m_phase = 2;
          m_ptr = (pick + 1) % l_pc;
        end else if (t_tick) begin
          if (m_cd == 1) begin m_cd = 0; m_rv = 0; m_phase = 3; end
          else if (m_cd > 0) m_cd--;
        end
      end
      2: begin
        if (t_ok) begin
          m_sc[m_resp] = (m_sc[m_resp] + l_ss > 99) ? 99 : m_sc[m_resp] + l_ss;
          m_phase = 3;
        end else if (t_fail || (t_tick && m_cd == 1)) begin
          m_sc[m_resp] = (m_sc[m_resp] < l_fs) ? 0 : m_sc[m_resp] - l_fs;
          if (!t_fail) m_cd = 0;
          m_phase = 3;
        end else if (t_tick && m_cd > 0) m_cd--;
      end
      3: begin
        lead = -1;
        for (int i = 0; i < l_pc; i++) if (lead < 0 && m_sc[i] >= l_ws) lead = i;
        if (lead >= 0) begin
          m_win = lead; m_wv = 1; m_phase = 4;
        end else if (m_q == l_qc) begin
          best = -1; nbest = 0; bidx = 0;
          for (int i = 0; i < l_pc; i++) if (m_sc[i] > best) begin best = m_sc[i]; bidx = i; end
          for (int i = 0; i < l_pc; i++) if (m_sc[i] == best) nbest++;
          m_win = (nbest == 1) ? bidx : 0;
          m_wv  = (nbest == 1) ? 1 : 0;
          m_phase = 4;
        end else if (t_start) begin
          m_q++; m_rv = 0; m_cd = l_at; m_phase = 1;
        end
      end
      4: if (t_start) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("phase", int'(bus.phase), m_phase);
    check_val("question_no", int'(bus.question_no), m_q);
    check_val("countdown", int'(bus.countdown), m_cd);
    check_val("responder_valid", int'(bus.responder_valid), m_rv);
    if (m_rv != 0) check_val("responder", int'(bus.responder), m_resp);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("score%0d", i), int'(bus.scores[7*i +: 7]), m_sc[i]);
    check_val("winner_valid", int'(bus.winner_valid), m_wv);
    check_val("winner", int'(bus.winner), m_win);
  endtask

  task automatic cyc(input logic [3:0] b, input logic st, input logic ok,
                     input logic fl, input logic tk);
    t_buzz = b; t_start = st; t_ok = ok; t_fail = fl; t_tick = tk;
    step();
    t_buzz = 4'd0; t_start = 1'b0; t_ok = 1'b0; t_fail = 1'b0; t_tick = 1'b0;
  endtask

  task automatic settings(input int pc, qc, at, ws, ss, fs);
    s_pc = pc; s_qc = qc; s_at = at; s_ws = ws; s_ss = ss; s_fs = fs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(4'd0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    t_buzz = 4'd0; t_start = 1'b0; t_ok = 1'b0; t_fail = 1'b0; t_tick = 1'b0;
    settings(3, 9, 3, 99, 5, 3);
    step();
    step();
    rst = 1'b0;
    check_val("rst_phase", int'(bus.phase), 0);
    check_val("rst_scores", int'(bus.scores), 0);

    // Ineligible player ignored, then second buzz selects player 2
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b1000, 0, 0, 0, 0);
    check_val("p3_ignored_phase", int'(bus.phase), 1);
    cyc(4'b0100, 0, 0, 0, 0);
    check_val("buzz_p2_resp", int'(bus.responder), 2);
    check_val("buzz_p2_phase", int'(bus.phase), 2);
    cyc(4'd0, 0, 1, 0, 0);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0110, 0, 0, 0, 0);
    check_val("tie_first_resp", int'(bus.responder), 1);
    cyc(4'd0, 0, 0, 1, 0);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0110, 0, 0, 0, 0);
`ifdef ROTATING_PRIORITY_EN
    check_val("tie_second_resp", int'(bus.responder), 2);
`else
    check_val("tie_second_resp", int'(bus.responder), 1);
`endif
    cyc(4'd0, 0, 1, 0, 0);
    // Unanswered question times out on the third tick
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'd0, 0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0, 0);
    cyc(4'd0, 0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0, 1);
    check_val("timeout_phase", int'(bus.phase), 3);
    check_val("timeout_cd", int'(bus.countdown), 0);

    // Reaching win_score ends the game two cycles after the verdict
    do_reset();
    settings(2, 9, 2, 10, 5, 3);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'd0, 0, 1, 0, 0);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'd0, 0, 1, 0, 0);
    check_val("win_score0", int'(bus.scores[6:0]), 10);
    check_val("win_show", int'(bus.phase), 3);
    cyc(4'd0, 0, 0, 0, 0);
    check_val("win_over", int'(bus.phase), 4);
    check_val("win_winner", int'(bus.winner), 0);
    check_val("win_valid", int'(bus.winner_valid), 1);

    // Single-question game with no answers is a draw
    cyc(4'd0, 1, 0, 0, 0);
    settings(2, 1, 1, 10, 1, 3);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'd0, 0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0, 0);
    check_val("draw_over", int'(bus.phase), 4);
    check_val("draw_valid", int'(bus.winner_valid), 0);

    // Saturation at zero, judge beating a same-cycle timeout, mid-game reset
    cyc(4'd0, 1, 0, 0, 0);
    settings(2, 9, 2, 10, 1, 3);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0, 0);
    cyc(4'd0, 0, 1, 0, 0);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0, 0);
    cyc(4'd0, 0, 0, 1, 0);
    check_val("sat_zero_score1", int'(bus.scores[13:7]), 0);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'd0, 0, 0, 0, 1);
    cyc(4'd0, 0, 1, 0, 1);
    check_val("ok_vs_tick_score0", int'(bus.scores[6:0]), 1);
    cyc(4'd0, 1, 0, 0, 0);
    cyc(4'b0001, 0, 0, 0, 0);
    do_reset();
    check_val("midrst_phase", int'(bus.phase), 0);
    check_val("midrst_scores", int'(bus.scores), 0);
    check_val("midrst_rv", int'(bus.responder_valid), 0);

    // Random play; settings wander every cycle to exercise the latch
    for (int n = 0; n < 6000; n++) begin
      rst     = ($urandom_range(0, 499) == 0);
      t_tick  = ($urandom_range(0, 3) == 0);
      t_start = ($urandom_range(0, 5) == 0);
      t_ok    = ($urandom_range(0, 6) == 0);
      t_fail  = ($urandom_range(0, 6) == 0);
      t_buzz  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      settings($urandom_range(2, 4), $urandom_range(1, 4), $urandom_range(1, 4),
               $urandom_range(1, 15), $urandom_range(1, 9), $urandom_range(1, 9));
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quiz_round_control.md
# quiz_round_control

Sequences a quiz game using the latched values from the settings controller. It opens and closes the buzzer window, picks one responder among up to four players, and runs the per-question answer countdown. It applies host judgements to per-player scores and declares the winner. It sits between the input debouncers/edge detectors and the display view logic, and is active while the game view is selected.

## Interface
- No parameters; player count max is fixed at 4 (package constant).
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high; clock clk
- tick_1hz  in  1  one-cycle pulse, once per second
- start  in  1  host edge pulse; starts the game / advances to the next question
- judge_ok, judge_fail  in  1  host edge pulses; verdict on the current responder
- buzz  in  4  player edge pulses, bit i = player i
- player_count  in  3  2..4
- question_count  in  4  1..9
- answer_time  in  7  1..99 seconds
- win_score  in  7  1..99
- success_score, fail_score  in  4  1..9
- phase  out  3  IDLE=0, OPEN=1, ANSWER=2, SHOW=3, OVER=4
- question_no  out  4  current question, 1-based
- countdown  out  7  seconds remaining
- responder  out  2  selected player; responder_valid out 1
- scores  out  28  4×7-bit packed, player i at [7i+6:7i]
- winner  out  2; winner_valid  out  1  (0 in OVER = draw)

## Operation
- Reset: phase=IDLE, question_no=0, countdown=0, responder=0, responder_valid=0, scores=0, winner=0, winner_valid=0.
- IDLE: on start, latch all six settings into internal copies, clear scores, set question_no=1, countdown=latched answer_time, go to OPEN. Setting changes after the latch have no effect until the next IDLE.
- OPEN: only buzz[i] with i < player_count is eligible.
  - If any eligible buzz arrives, select a single responder by tie-break (see Configuration), set responder_valid=1, reload countdown=answer_time, go to ANSWER.
  - On tick with countdown==1: countdown=0, go to SHOW with no score change and responder_valid=0.
- ANSWER: buzzes are ignored.
  - judge_ok: responder score += success_score, saturating at 99.
  - judge_fail, or tick with countdown==1: score -= fail_score, saturating at 0.
  - Either verdict goes to SHOW.
- SHOW:
  - If any score ≥ win_score: go to OVER; winner = lowest-index player meeting it; winner_valid=1.
  - Else if question_no == question_count: go to OVER; winner = unique max score, winner_valid=1; on a tie for max, winner_valid=0.
  - Else wait for start: question_no+1, responder_valid=0, countdown reload, go to OPEN.
- OVER: holds all outputs. start returns to IDLE; scores are kept until the next game start.
- start is ignored in OPEN and ANSWER. judge_* are ignored outside ANSWER.

## Timing
- All outputs are registered. A buzz in cycle N gives responder_valid/phase=ANSWER in N+1.
- Verdict in cycle N updates the score in N+1 (phase=SHOW). The win/end check uses the updated score and is evaluated in the first SHOW cycle, so OVER is reached at N+2.
- countdown decrements on each tick while in OPEN/ANSWER. The timeout transition happens on the tick that sees countdown==1.
- Simultaneous events in one cycle:
  - judge_ok and judge_fail together: judge_ok wins.
  - judge and timeout tick together: the judge wins.
  - buzz and timeout tick in OPEN together: the buzz wins.
- rst mid-game forces reset values in the next cycle.

## Configuration
- ROTATING_PRIORITY_EN defined: the tie-break among simultaneous eligible buzzes is round-robin. Search starts at (last selected responder + 1) mod player_count; the pointer resets to 0 on rst and on game start.
- Undefined: fixed priority, lowest index wins.

## Structure
- Shared package `quiz_pkg`: phase encoding constants, MAX_PLAYERS=4, SCORE_MAX=99, score width 7.
- One sub-module `buzz_arbiter`: combinational request mask + priority/round-robin pick, giving grant index and valid; it holds the rotate pointer when enabled.
- Score saturation and the FSM live in the top module.

## Test plan
- player_count=3, start, buzz=4'b1000 then 4'b0100 → player 3 ignored, responder=2 one cycle after the second buzz.
- buzz=4'b0110 same cycle, fixed priority → responder=1. With ROTATING_PRIORITY_EN after a previous pick of 1, the next simultaneous 0110 → responder=2.
- answer_time=3, no buzz, 3 ticks → SHOW on the third tick with countdown=0, scores unchanged.
- success_score=5, win_score=10, player 0 correct twice → score 10, OVER two cycles after the verdict, winner=0, winner_valid=1.
- fail_score=3, player 1 score 1, judge_fail → score 0 (saturated). judge_ok and tick at countdown==1 in the same cycle → score increments.
- question_count=1, no scores, timeout then SHOW → OVER with winner_valid=0 (draw). rst asserted in ANSWER → all outputs at reset values next cycle.
